// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder/subtractor: WIDTH bits split into STAGES slices,
// one slice per stage, with registered inter-slice carries and skew/de-skew registers.
module pipelined_cpa #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub | cin;
  assign in_ready = out_ready || !out_valid;

  // One slice: 4-bit lookahead groups, group carry rippled from group to group.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0] s;
    logic [3:0]    g;
    logic [3:0]    p;
    logic [4:0]    cc;
    logic          c;
    s = '0;
    c = ci;
    for (int j = 0; j < SW / 4; j++) begin
      g     = x[4*j +: 4] & y[4*j +: 4];
      p     = x[4*j +: 4] ^ y[4*j +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
      s[4*j +: 4] = p ^ cc[3:0];
      c = cc[4];
    end
    return {c, s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int DW = (k + 1) * SW;   // sum bits complete after this stage
    localparam int IW = WIDTH - k * SW; // operand bits still to be summed

    logic [IW-1:0] ain;
    logic [IW-1:0] bin;
    logic          ci;
    logic          vin;
    logic [DW-1:0] sum_n;
    logic [DW-1:0] sum_p;
    logic          cy_n;
    logic          cy_p;
    logic          vld_p;

    // Stage k input boundary: ports for slice 0, previous stage registers otherwise
    if (k == 0) begin : head
      assign ain = a;
      assign bin = b_eff;
      assign ci  = c_eff;
      assign vin = in_valid;
    end else begin : body
      assign ain              = stg[k-1].skw.a_p;
      assign bin              = stg[k-1].skw.b_p;
      assign ci               = stg[k-1].cy_p;
      assign vin              = stg[k-1].vld_p;
      assign sum_n[DW-SW-1:0] = stg[k-1].sum_p;
    end

    assign {cy_n, sum_n[DW-1 -: SW]} = slice_add(ain[SW-1:0], bin[SW-1:0], ci);

    // Stage k output boundary: the whole pipeline advances together on in_ready
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        cy_p  <= 1'b0;
        sum_p <= '0;
      end else if (in_ready) begin
        vld_p <= vin;
        cy_p  <= cy_n;
        sum_p <= sum_n;
      end
    end

    if (k < STAGES - 1) begin : skw
      logic [IW-SW-1:0] a_p;
      logic [IW-SW-1:0] b_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (in_ready) begin
          a_p <= ain[IW-1:SW];
          b_p <= bin[IW-1:SW];
        end
      end
    end else begin : fin
      // Carry into the MSB recovered as sum ^ a ^ b at that bit.
      logic ovf_p;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (in_ready) begin
          ovf_p <= cy_n ^ ain[SW-1] ^ bin[SW-1] ^ sum_n[DW-1];
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].vld_p;
  assign sum       = stg[STAGES-1].sum_p;
  assign cout      = stg[STAGES-1].cy_p;
  assign ovf       = stg[STAGES-1].fin.ovf_p;

endmodule

// File: tb/tb_pipelined_cpa.sv
// Bench for pipelined_cpa: 64/4, 32/1 and 48/3 instances driven from shared operands.
module tb_pipelined_cpa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_valid2, out_ready, cin, sub;
  logic [63:0] a, b;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [63:0] s0;
  logic [31:0] s1;
  logic [47:0] s2;

  int tests = 0;
  int fails = 0;

  pipelined_cpa #(.WIDTH(64), .STAGES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready), .sum(s0),
    .cout(co0), .ovf(of0));
  pipelined_cpa #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(rdy1), .a(a[31:0]),
    .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(1'b1), .sum(s1),
    .cout(co1), .ovf(of1));
  pipelined_cpa #(.WIDTH(48), .STAGES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(rdy2), .a(a[47:0]),
    .b(b[47:0]), .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(1'b1), .sum(s2),
    .cout(co2), .ovf(of2));

  typedef struct packed {logic [63:0] s; logic c; logic o;} res_t;
  typedef struct {logic [63:0] a; logic [63:0] b; logic cin; logic sub;
                  logic [63:0] s; logic c; logic o;} vec_t;

  vec_t tab[10];
  res_t q0[$], q1[$], q2[$];
  int   got0, got1, got2, cyc, first0, last0;
  bit   mon_en, pstall;
  logic [63:0] psum;

  function automatic res_t model(int w, logic [63:0] x, logic [63:0] y, logic ci, logic sb);
    logic [63:0] m, xa, ya;
    logic [64:0] f;
    res_t r;
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xa = x & m;
    ya = (sb ? ~y : y) & m;
    f  = {1'b0, xa} + {1'b0, ya} + {64'd0, (sb | ci)};
    r.s = f[63:0] & m;
    r.c = f[w];
    r.o = (xa[w-1] == ya[w-1]) && (r.s[w-1] != xa[w-1]);
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    tests++;
    fails++;
    $display("FAIL %s: condition not met", nm);
  endtask

  // Scoreboard: push expected at acceptance, pop and compare at each output transfer.
  task automatic monitor();
    res_t e;
    cyc++;
    if (mon_en && rst_n) begin
      chk("in_ready_rule", 64'(rdy0), 64'(out_ready || !ov0));
      if (pstall) begin
        chk("stall_hold_valid", 64'(ov0), 64'd1);
        chk("stall_hold_sum", s0, psum);
      end
      pstall = ov0 && !out_ready;
      psum   = s0;
      if (in_valid && rdy0)  q0.push_back(model(64, a, b, cin, sub));
      if (in_valid2 && rdy1) q1.push_back(model(32, a, b, cin, sub));
      if (in_valid2 && rdy2) q2.push_back(model(48, a, b, cin, sub));
      if (ov0 && out_ready) begin
        if (q0.size() == 0) fail_now("extra_result_64");
        else begin
          e = q0.pop_front();
          chk("stream_sum64", s0, e.s);
          chk("stream_cout64", 64'(co0), 64'(e.c));
          chk("stream_ovf64", 64'(of0), 64'(e.o));
          got0++;
          if (got0 == 1) first0 = cyc;
          last0 = cyc;
        end
      end
      if (ov1) begin
        if (q1.size() == 0) fail_now("extra_result_32");
        else begin
          e = q1.pop_front();
          chk("stream_sum32", 64'(s1), e.s);
          chk("stream_cout32", 64'(co1), 64'(e.c));
          chk("stream_ovf32", 64'(of1), 64'(e.o));
          got1++;
        end
      end
      if (ov2) begin
        if (q2.size() == 0) fail_now("extra_result_48");
        else begin
          e = q2.pop_front();
          chk("stream_sum48", 64'(s2), e.s);
          chk("stream_cout48", 64'(co2), 64'(e.c));
          chk("stream_ovf48", 64'(of2), 64'(e.o));
          got2++;
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  // One isolated operation: measures latency of each instance and checks its result.
  task automatic run_tab(vec_t v);
    int   l0, l1, l2;
    logic [63:0] cs0, cs1, cs2;
    logic cc0, cc1, cc2, co0f, co1f, co2f;
    res_t e1, e2;
    l0 = 0; l1 = 0; l2 = 0;
    cs0 = '0; cs1 = '0; cs2 = '0;
    cc0 = 0; cc1 = 0; cc2 = 0; co0f = 0; co1f = 0; co2f = 0;
    @(posedge clk); #1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; in_valid2 = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid2 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (ov0 && l0 == 0) begin l0 = n; cs0 = s0; cc0 = co0; co0f = of0; end
      if (ov1 && l1 == 0) begin l1 = n; cs1 = 64'(s1); cc1 = co1; co1f = of1; end
      if (ov2 && l2 == 0) begin l2 = n; cs2 = 64'(s2); cc2 = co2; co2f = of2; end
    end
    e1 = model(32, v.a, v.b, v.cin, v.sub);
    e2 = model(48, v.a, v.b, v.cin, v.sub);
    chk("latency64", 64'(l0), 64'd4);
    chk("sum64", cs0, v.s);
    chk("cout64", 64'(cc0), 64'(v.c));
    chk("ovf64", 64'(co0f), 64'(v.o));
    chk("latency32", 64'(l1), 64'd1);
    chk("sum32", cs1, e1.s);
    chk("cout32", 64'(cc1), 64'(e1.c));
    chk("ovf32", 64'(co1f), 64'(e1.o));
    chk("latency48", 64'(l2), 64'd3);
    chk("sum48", cs2, e2.s);
    chk("cout48", 64'(cc2), 64'(e2.c));
    chk("ovf48", 64'(co2f), 64'(e2.o));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, guard;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; mon_en = 1'b0; pstall = 1'b0;
    psum = '0; cyc = 0; got0 = 0; got1 = 0; got2 = 0; first0 = 0; last0 = 0;

    tab[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    tab[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tab[2] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tab[3] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
    tab[4] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
    tab[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    tab[6] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tab[7] = '{64'hA, 64'h3, 1'b1, 1'b1, 64'h7, 1'b1, 1'b0};
    tab[8] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    tab[9] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
               64'h0001_0000_0001_0000, 1'b0, 1'b0};

    #2;
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_sum", s0, 64'd0);
    chk("reset_cout", 64'(co0), 64'd0);
    chk("reset_ovf", 64'(of0), 64'd0);
    chk("reset_in_ready", 64'(rdy0), 64'd1);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_tab(tab[i]);

    // Back-to-back stream on all three instances.
    got0 = 0; got1 = 0; got2 = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1; in_valid2 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_valid2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_count64", 64'(got0), 64'd100);
    chk("b2b_count32", 64'(got1), 64'd100);
    chk("b2b_count48", 64'(got2), 64'd100);
    chk("b2b_one_per_cycle", 64'(last0 - first0), 64'd99);
    chk("b2b_left64", 64'(q0.size()), 64'd0);

    // Random gaps on input and random backpressure on the 64-bit instance.
    got0 = 0; k = 0; guard = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    while (k < 100 && guard < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && rdy0;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        k++;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = 1'($urandom); sub = 1'($urandom);
      end
    end
    if (guard >= 5000) fail_now("stall_stream_budget");
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_count64", 64'(got0), 64'd100);
    chk("stall_left64", 64'(q0.size()), 64'd0);

    // Reset with work in flight and a result held at the output.
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = 64'h1234 + 64'(i); b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("prereset_valid", 64'(ov0), 64'd1);
    chk("prereset_sum", s0, 64'h1235);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(ov0), 64'd0);
    chk("async_rst_sum", s0, 64'd0);
    chk("async_rst_cout", 64'(co0), 64'd0);
    chk("async_rst_ovf", 64'(of0), 64'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(rdy0), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale_valid", 64'(ov0), 64'd0);
    end
    run_tab(tab[0]);
    run_tab(tab[6]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_cpa.md
PIPELINED_CPA -- requirements
Module: pipelined_cpa

Interface
REQ-001 Parameter WIDTH, default 64, operand/sum width in bits; SHALL be a multiple of 4*STAGES.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL be 1..WIDTH/4.
REQ-003 Port clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  operand set a/b/cin/sub presented.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a  input  WIDTH  first operand.
REQ-008 Port b  input  WIDTH  second operand.
REQ-009 Port cin  input  1  carry-in; ignored when sub=1.
REQ-010 Port sub  input  1  0: a+b+cin; 1: a+~b+1 (a-b).
REQ-011 Port out_valid  output  1  sum/cout/ovf hold a result.
REQ-012 Port out_ready  input  1  downstream accepts result.
REQ-013 Port sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-014 Port cout  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 Port ovf  output  1  signed two's-complement overflow of the operation.

Function
REQ-016 Datapath SHALL be split into STAGES slices of SW=WIDTH/STAGES bits; slice k (k=0 lowest) SHALL be computed in stage k from stage-k operand bits and the registered carry from stage k-1.
REQ-017 Each slice SHALL be built from 4-bit carry-lookahead groups rippling group carries within the slice; no inter-slice combinational carry path.
REQ-018 Operand bits of slices not yet summed SHALL be carried forward in skew registers; completed sum bits SHALL be carried forward in de-skew registers so all WIDTH bits emerge aligned.
REQ-019 Effective b SHALL be ~b and effective carry-in 1 when sub=1, captured at acceptance.
REQ-020 Handshake: transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
REQ-021 in_ready SHALL equal out_ready || !out_valid (whole pipeline stalls as one unit).
REQ-022 When in_ready=0, every stage register (data and valid) SHALL hold.
REQ-023 Latency: operands accepted at edge t SHALL appear on sum/cout/ovf with out_valid=1 after edge t+STAGES-1 (STAGES edges inclusive), given no stall.
REQ-024 Throughput SHALL be one result per cycle with out_ready held high.
REQ-025 Bubbles (in_valid=0 while in_ready=1) SHALL propagate as invalid stages; outputs of invalid stages are don't-care except as in REQ-029.
REQ-026 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-027 Results SHALL exit in acceptance order; no result SHALL be dropped or duplicated under any out_ready pattern.
REQ-028 Simultaneous accept and emit in one cycle SHALL both occur (full pipeline at one per cycle).

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, sum=0, cout=0, ovf=0, and all carry/skew registers to 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; no result from before reset SHALL ever be emitted.
REQ-031 After rst_n deasserts, in_ready SHALL be 1 and the first accept may occur on the first rising edge.

Verification
REQ-032 WIDTH=64, STAGES=4: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> after 4 edges sum=0, cout=1, ovf=0 (carry crosses every stage boundary).
REQ-033 a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=8000_0000_0000_0000, cout=0, ovf=1; a=5, b=7, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-034 Stream 100 random operands back-to-back with out_ready=1 -> 100 results, one per cycle, in order, matching a+b+cin / a-b reference model.
REQ-035 Same stream with out_ready randomly toggled (~50%) and in_valid randomly gapped -> identical ordered result list; in_ready tracks REQ-021 every cycle.
REQ-036 Fill pipeline with 3 operations, assert rst_n low between edges -> outputs zero immediately; after release no stale out_valid appears; next accepted op emerges after 4 edges.
REQ-037 Repeat REQ-032..REQ-034 with WIDTH=32, STAGES=1 and WIDTH=48, STAGES=3 -> latency 1 and 3 respectively, results correct.
